// File: rtl/nx_meas_ingest.sv
// nx_meas_ingest
//   Accepts (x, y, target id) measurements on an AXI-Stream style input,
//   stamps each one with the time since that target's previous measurement,
//   and queues the result in a small FIFO for a downstream tracker.
//
//   Optional feature macro: NX_MEAS_GATE_EN
//     defined   : beats whose |x| or |y| exceeds gate_limit are consumed and
//                 counted in drop_count instead of being queued
//     undefined : gate_limit is ignored, every beat is queued, drop_count = 0
//
// Ports
//   clk, rst_n        250 MHz clock, asynchronous active-low reset
//   tick_1ms          one-cycle millisecond strobe (advances the ms counter)
//   flush             synchronous clear of queue, seen bits and drop_count
//   gate_limit        Q15.16 magnitude gate (NX_MEAS_GATE_EN only)
//   s_axis_*          input beats: tdata[31:0]=x, tdata[63:32]=y, tuser=tid
//   m_valid/m_ready   output handshake; m_x, m_y, m_tid, m_dt, m_first
//                     describe the head of the queue
//   drop_count        saturating count of gated-out beats

module nx_meas_ingest #(
    parameter int          MAX_TARGETS = 8,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] DT_FIRST    = 32'h0000_199A
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tick_1ms,
    input  logic                           flush,
    input  logic [31:0]                    gate_limit,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [63:0]                    s_axis_tdata,
    input  logic [$clog2(MAX_TARGETS)-1:0] s_axis_tuser,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [31:0]                    m_x,
    output logic [31:0]                    m_y,
    output logic [$clog2(MAX_TARGETS)-1:0] m_tid,
    output logic [31:0]                    m_dt,
    output logic                           m_first,
    output logic [15:0]                    drop_count
);

    localparam int TID_W = $clog2(MAX_TARGETS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic [TID_W-1:0]   tid;
        logic [31:0]        dt;
        logic               first;
    } entry_t;

    // ms -> Q15.16 seconds: 67109/1024 ~= 65.536 (= 2^16 / 1000), truncated.
    // A zero interval still reports the smallest nonzero dt.
    function automatic logic [31:0] ms_to_dt(input logic [15:0] elapsed);
        logic [32:0] prod;
        prod = {17'd0, elapsed} * 33'd67109;
        if (elapsed == 16'd0) return 32'h0000_0001;
        return 32'(prod >> 10);
    endfunction

    logic [15:0]      ms_now;
    logic [MAX_TARGETS-1:0] seen;
    logic [15:0]      last_ms [MAX_TARGETS];
    entry_t           mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             ready_en;
    logic             fifo_empty;
    logic             fifo_full;
    logic             accept;
    logic             gated;
    logic             push;
    logic             pop;
    logic [15:0]      elapsed_p0;
    entry_t           in_entry_p0;
    entry_t           head;

    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // ready_en keeps tready low in reset and lets it rise on the first edge after.
    assign s_axis_tready = ready_en && !fifo_full && !flush;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign push          = accept && !gated;
    assign pop           = m_valid && m_ready && !flush;

`ifdef NX_MEAS_GATE_EN
    // Two's-complement minimum has no positive twin; clamp it to max.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
        if (v == 32'sh8000_0000) return 32'h7FFF_FFFF;
        if (v < 0) return 32'(-v);
        return 32'(v);
    endfunction

    logic [15:0] drop_cnt;

    assign gated = (abs_sat($signed(s_axis_tdata[31:0]))  > gate_limit) ||
                   (abs_sat($signed(s_axis_tdata[63:32])) > gate_limit);
    assign drop_count = drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
        end else if (flush) begin
            drop_cnt <= 16'd0;
        end else if (accept && gated && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    logic unused_gate_limit;

    assign gated             = 1'b0;
    assign drop_count        = 16'd0;
    assign unused_gate_limit = ^gate_limit;
`endif

    // Stage p0: timestamp the incoming beat against its target's last arrival.
    // ms_now is the pre-increment value even when tick_1ms is high this cycle.
    always_comb begin
        elapsed_p0        = ms_now - last_ms[s_axis_tuser];
        in_entry_p0.x     = $signed(s_axis_tdata[31:0]);
        in_entry_p0.y     = $signed(s_axis_tdata[63:32]);
        in_entry_p0.tid   = s_axis_tuser;
        in_entry_p0.dt    = seen[s_axis_tuser] ? ms_to_dt(elapsed_p0) : DT_FIRST;
        in_entry_p0.first = !seen[s_axis_tuser];
    end

    // Control state: counter, seen bits, queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            ms_now   <= 16'd0;
            seen     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (tick_1ms) ms_now <= ms_now + 16'd1;
            if (flush) begin
                seen   <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    seen[s_axis_tuser] <= 1'b1;
                    wr_ptr             <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Stage p1: queue storage and per-target timestamps (no reset needed;
    // seen bits and pointers decide what is meaningful).
    always_ff @(posedge clk) begin
        if (push) begin
            last_ms[s_axis_tuser]  <= ms_now;
            mem[wr_ptr[AW-1:0]]    <= in_entry_p0;
        end
    end

    // Head of queue; outputs read zero whenever the queue is empty.
    assign head    = mem[rd_ptr[AW-1:0]];
    assign m_valid = !fifo_empty;
    assign m_x     = m_valid ? head.x     : '0;
    assign m_y     = m_valid ? head.y     : '0;
    assign m_tid   = m_valid ? head.tid   : '0;
    assign m_dt    = m_valid ? head.dt    : '0;
    assign m_first = m_valid ? head.first : 1'b0;

endmodule

// File: tb/tb_nx_meas_ingest.sv
// Bench for nx_meas_ingest (default build, NX_MEAS_GATE_EN undefined).
// A queue-based model tracks what the output queue must hold; a compare
// process checks the DUT against it on every falling edge, and directed
// literal checks pin the model's arithmetic.

module tb_nx_meas_ingest;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1ms;
    logic        flush;
    logic [31:0] gate_limit;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [2:0]  s_axis_tuser;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_x;
    logic [31:0] m_y;
    logic [2:0]  m_tid;
    logic [31:0] m_dt;
    logic        m_first;
    logic [15:0] drop_count;

    always #2 clk = ~clk;

    nx_meas_ingest dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_1ms      (tick_1ms),
        .flush         (flush),
        .gate_limit    (gate_limit),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_x           (m_x),
        .m_y           (m_y),
        .m_tid         (m_tid),
        .m_dt          (m_dt),
        .m_first       (m_first),
        .drop_count    (drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  tid;
        logic [31:0] dt;
        bit          first;
    } ent_t;

    ent_t        mq[$];
    int unsigned mms;
    bit          mseen [8];
    int unsigned mlast [8];
    bit          mrdy;
    bit          m_acc;
    bit          m_pop;
    int unsigned m_el;
    ent_t        m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mms  = 0;
            mrdy = 0;
            foreach (mseen[i]) mseen[i] = 0;
        end else begin
            m_acc = s_axis_tvalid && mrdy && !flush && (mq.size() < 4);
            m_pop = (mq.size() != 0) && m_ready && !flush;
            if (flush) begin
                mq.delete();
                foreach (mseen[i]) mseen[i] = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) begin
                    m_e.x   = s_axis_tdata[31:0];
                    m_e.y   = s_axis_tdata[63:32];
                    m_e.tid = s_axis_tuser;
                    if (!mseen[s_axis_tuser]) begin
                        m_e.dt    = 32'h0000_199A;
                        m_e.first = 1;
                    end else begin
                        m_el      = (mms - mlast[s_axis_tuser]) % 65536;
                        m_e.first = 0;
                        m_e.dt    = (m_el == 0) ? 32'd1 : 32'((longint'(m_el) * 67109) / 1024);
                    end
                    mseen[s_axis_tuser] = 1;
                    mlast[s_axis_tuser] = mms;
                    mq.push_back(m_e);
                end
            end
            if (tick_1ms) mms = (mms + 1) % 65536;
            mrdy = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("m_valid", {31'd0, m_valid}, {31'd0, mq.size() != 0});
        chk("tready", {31'd0, s_axis_tready}, {31'd0, mrdy && (mq.size() < 4) && !flush});
        chk("drop_count", {16'd0, drop_count}, 32'd0);
        if (mq.size() != 0) begin
            chk("m_x", m_x, mq[0].x);
            chk("m_y", m_y, mq[0].y);
            chk("m_tid", {29'd0, m_tid}, {29'd0, mq[0].tid});
            chk("m_dt", m_dt, mq[0].dt);
            chk("m_first", {31'd0, m_first}, {31'd0, mq[0].first});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        tick_1ms = 1'b1;
        cyc(n);
        tick_1ms = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] tid);
        bit hs;
        int b;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {y, x};
        s_axis_tuser  = tid;
        hs = 0;
        b  = 0;
        while (!hs && b < 50) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            b++;
        end
        s_axis_tvalid = 1'b0;
        if (!hs) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout tid=%0d: tready stayed 0 for 50 cycles, expected a handshake", tid);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        tick_1ms      = 1'b0;
        flush         = 1'b0;
        gate_limit    = 32'h0064_0000;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        m_ready       = 1'b1;

        // reset state
        cyc(3);
        @(negedge clk);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_m_x", m_x, 32'd0);
        chk("rst_m_dt", m_dt, 32'd0);
        chk("rst_m_first", {31'd0, m_first}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("tready_before_edge", {31'd0, s_axis_tready}, 32'd0);
        @(negedge clk);
        chk("tready_after_edge", {31'd0, s_axis_tready}, 32'd1);
        cyc(1);

        // first measurement of tid 3
        send(32'h0001_0000, 32'hFFFF_0000, 3'd3);
        @(negedge clk);
        chk("first_valid", {31'd0, m_valid}, 32'd1);
        chk("first_dt", m_dt, 32'h0000_199A);
        chk("first_flag", {31'd0, m_first}, 32'd1);
        chk("first_y", m_y, 32'hFFFF_0000);
        chk("first_tid", {29'd0, m_tid}, 32'd3);
        cyc(1);

        // 100 ms then 1000 ms later
        ticks(100);
        send(32'h0002_0000, 32'h0003_0000, 3'd3);
        @(negedge clk);
        chk("dt_100ms", m_dt, 32'h0000_1999);
        chk("flag_100ms", {31'd0, m_first}, 32'd0);
        cyc(1);
        ticks(1000);
        send(32'h0004_0000, 32'h0005_0000, 3'd3);
        @(negedge clk);
        chk("dt_1000ms", m_dt, 32'h0001_0000);
        cyc(1);

        // backpressure: four fill the queue, the fifth waits
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(32'h0000_1000 * (i + 1), 32'h0000_0100 * (i + 1), 3'(i));
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {32'h0000_0500, 32'h0000_5000};
        s_axis_tuser  = 3'd4;
        @(negedge clk);
        chk("tready_full", {31'd0, s_axis_tready}, 32'd0);
        chk("head_stalled", m_x, 32'h0000_1000);
        cyc(3);
        @(negedge clk);
        chk("head_held", m_x, 32'h0000_1000);
        cyc(1);
        m_ready = 1'b1;
        send(32'h0000_5000, 32'h0000_0500, 3'd4);
        cyc(8);

        // flush with three queued entries
        m_ready = 1'b0;
        send(32'h0000_0010, 32'h0000_0020, 3'd3);
        send(32'h0000_0030, 32'h0000_0040, 3'd1);
        send(32'h0000_0050, 32'h0000_0060, 3'd2);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_empty", {31'd0, m_valid}, 32'd0);
        cyc(1);
        m_ready = 1'b1;
        send(32'h0000_0070, 32'h0000_0080, 3'd3);
        @(negedge clk);
        chk("flush_first", {31'd0, m_first}, 32'd1);
        chk("flush_first_dt", m_dt, 32'h0000_199A);
        cyc(1);

        // large x passes through when gating is compiled out
        send(32'h00C8_0000, 32'h0000_0000, 3'd6);
        @(negedge clk);
        chk("ungated_valid", {31'd0, m_valid}, 32'd1);
        chk("ungated_x", m_x, 32'h00C8_0000);
        chk("ungated_drop", {16'd0, drop_count}, 32'd0);
        cyc(1);

        // tick coincident with accept: table takes the pre-increment count
        tick_1ms = 1'b1;
        send(32'h0000_0001, 32'h0000_0002, 3'd3);
        tick_1ms = 1'b0;
        @(negedge clk);
        chk("tick_coincide_dt", m_dt, 32'h0000_0001);
        cyc(1);
        send(32'h0000_0003, 32'h0000_0004, 3'd3);
        @(negedge clk);
        chk("one_ms_dt", m_dt, 32'h0000_0041);
        cyc(1);

        // counter wrap: last_ms = 0xFFF0, then 26 ticks to 0x000A
        ticks(int'(32'h0000_FFF0 - mms));
        send(32'h0000_0005, 32'h0000_0006, 3'd3);
        cyc(1);
        ticks(26);
        send(32'h0000_0007, 32'h0000_0008, 3'd3);
        @(negedge clk);
        chk("wrap_dt", m_dt, 32'h0000_06A7);
        cyc(1);
        send(32'h0000_0009, 32'h0000_000A, 3'd3);
        @(negedge clk);
        chk("zero_elapsed_dt", m_dt, 32'h0000_0001);
        cyc(1);

        // reset mid-stream discards queued entries
        m_ready = 1'b0;
        send(32'h0000_0011, 32'h0000_0012, 3'd5);
        send(32'h0000_0013, 32'h0000_0014, 3'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_tready", {31'd0, s_axis_tready}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        m_ready = 1'b1;
        send(32'h0000_0015, 32'h0000_0016, 3'd3);
        @(negedge clk);
        chk("midrst_first", {31'd0, m_first}, 32'd1);
        chk("midrst_x", m_x, 32'h0000_0015);
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
